// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  localparam int MAX_WAIT_DEF = 4;
  localparam int WAIT_CTR_W   = 4;

  // Identifies which requester owns the read response arriving next cycle.
  typedef struct packed {
    logic rd_pend;
    logic rd_port;
  } owner_tag_t;

  function automatic owner_tag_t make_tag(input logic is_read, input logic port);
    owner_tag_t t;
    t.rd_pend = is_read;
    t.rd_port = port;
    return t;
  endfunction

endpackage

// File: rtl/mem_arb_wait_ctr.sv
// Saturating aging counter: counts consecutive cycles a fetch request is refused
// and raises force_o once MAX_WAIT refusals have accumulated.
module mem_arb_wait_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic gnt_i,
  output logic force_o
);

  localparam logic [WAIT_CTR_W-1:0] LIMIT = WAIT_CTR_W'(MAX_WAIT);
  localparam logic [WAIT_CTR_W-1:0] ONE   = WAIT_CTR_W'(1);

  logic [WAIT_CTR_W-1:0] cnt_q;
  logic [WAIT_CTR_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || gnt_i) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data requesters, data first.
// Define ARB_AGING_EN to build the aging counter that forces starved fetches through.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_vld,
  output logic              if_rdy,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_vld,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              dm_vld,
  output logic              dm_rdy,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_rsp_vld,
  output logic [DATA_W-1:0] dm_rsp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Handshake: a request transfers in any cycle where its vld and rdy are both 1;
  // rdy is the combinational grant and is never a function of the requester's rdy.

  logic       force_fetch;
  logic       gnt_if;
  logic       gnt_dm;
  owner_tag_t tag_q;
  owner_tag_t tag_d;

`ifdef ARB_AGING_EN
  mem_arb_wait_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (if_vld),
    .gnt_i  (gnt_if),
    .force_o(force_fetch)
  );
`else
  localparam logic [WAIT_CTR_W-1:0] MAX_WAIT_L = WAIT_CTR_W'(MAX_WAIT);
  logic unused_max_wait;
  assign unused_max_wait = ^MAX_WAIT_L;
  assign force_fetch     = 1'b0;
`endif

  always_comb begin
    gnt_if = 1'b0;
    gnt_dm = 1'b0;
    if (force_fetch && if_vld) begin
      gnt_if = 1'b1;
    end else if (dm_vld) begin
      gnt_dm = 1'b1;
    end else if (if_vld) begin
      gnt_if = 1'b1;
    end
  end

  assign if_rdy = gnt_if;
  assign dm_rdy = gnt_dm;

  // Fetch address is the idle default so the address mux stays a single select.
  always_comb begin
    mem_en    = gnt_if | gnt_dm;
    mem_we    = 1'b0;
    mem_addr  = if_addr;
    mem_wdata = dm_wdata;
    if (gnt_dm) begin
      mem_we   = dm_we;
      mem_addr = dm_addr;
    end
  end

  always_comb begin
    tag_d = make_tag(mem_en & ~mem_we, gnt_dm ? PORT_DM : PORT_IF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign if_rsp_vld  = tag_q.rd_pend && (tag_q.rd_port == PORT_IF);
  assign dm_rsp_vld  = tag_q.rd_pend && (tag_q.rd_port == PORT_DM);
  assign if_rsp_data = mem_rdata;
  assign dm_rsp_data = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a cycle-level reference model and a memory stub.
module tb_mem_port_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;

  logic              clk;
  logic              rst_n;
  logic              if_vld;
  logic              if_rdy;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rsp_vld;
  logic [DATA_W-1:0] if_rsp_data;
  logic              dm_vld;
  logic              dm_rdy;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_rsp_vld;
  logic [DATA_W-1:0] dm_rsp_data;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  mem_port_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_vld     (if_vld),
    .if_rdy     (if_rdy),
    .if_addr    (if_addr),
    .if_rsp_vld (if_rsp_vld),
    .if_rsp_data(if_rsp_data),
    .dm_vld     (dm_vld),
    .dm_rdy     (dm_rdy),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_rsp_vld (dm_rsp_vld),
    .dm_rsp_data(dm_rsp_data),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory stub ----------------
  logic [DATA_W-1:0] env_mem [256];
  logic [DATA_W-1:0] exp_mem [256];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) env_mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= env_mem[mem_addr[7:0]];
    end
  end

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + compare ----------------
  // Responses are tracked as a queue of at most one in-flight read.
  logic [DATA_W-1:0] exp_q[$];
  logic              exp_port_q[$];
  int                m_wcnt;
  logic              e_force, e_gif, e_gdm, e_we;
  logic [ADDR_W-1:0] e_addr;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk1("rst_if_rsp_vld", if_rsp_vld, 1'b0);
      chk1("rst_dm_rsp_vld", dm_rsp_vld, 1'b0);
      exp_q.delete();
      exp_port_q.delete();
      m_wcnt = 0;
    end else begin
      e_force = 1'b0;
`ifdef ARB_AGING_EN
      e_force = (m_wcnt >= MAX_WAIT);
`endif
      e_gif  = if_vld && (e_force || !dm_vld);
      e_gdm  = dm_vld && !e_gif;
      e_we   = e_gdm && dm_we;
      e_addr = e_gdm ? dm_addr : if_addr;
      chk1("if_rdy", if_rdy, e_gif);
      chk1("dm_rdy", dm_rdy, e_gdm);
      chk1("mem_en", mem_en, e_gif || e_gdm);
      chk1("mem_we", mem_we, e_we);
      if (e_gif || e_gdm) chk32("mem_addr", mem_addr, e_addr);
      if (e_we) chk32("mem_wdata", mem_wdata, dm_wdata);

      if (exp_q.size() != 0) begin
        chk1("if_rsp_vld", if_rsp_vld, exp_port_q[0] == 1'b0);
        chk1("dm_rsp_vld", dm_rsp_vld, exp_port_q[0] == 1'b1);
        if (exp_port_q[0]) chk32("dm_rsp_data", dm_rsp_data, exp_q[0]);
        else               chk32("if_rsp_data", if_rsp_data, exp_q[0]);
        void'(exp_q.pop_front());
        void'(exp_port_q.pop_front());
      end else begin
        chk1("if_rsp_vld_idle", if_rsp_vld, 1'b0);
        chk1("dm_rsp_vld_idle", dm_rsp_vld, 1'b0);
      end

      if ((e_gif || e_gdm) && !e_we) begin
        exp_q.push_back(exp_mem[e_addr[7:0]]);
        exp_port_q.push_back(e_gdm);
      end
      if (e_we) exp_mem[e_addr[7:0]] = dm_wdata;
      if (!if_vld || e_gif) m_wcnt = 0;
      else if (m_wcnt < MAX_WAIT) m_wcnt = m_wcnt + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic iv, input logic [31:0] ia, input logic dv,
                       input logic dwe, input logic [31:0] da, input logic [31:0] dwd);
    if_vld   = iv;
    if_addr  = ia;
    dm_vld   = dv;
    dm_we    = dwe;
    dm_addr  = da;
    dm_wdata = dwd;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic        dwe;
    logic [31:0] da;
    logic [31:0] dwd;
  } vec_t;

  vec_t tv[8];
  int   first_if;
  int   first_dm_after;
  int   n_if_gnt;

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 32'hC0DE0000 | 32'(i);
      exp_mem[i] = 32'hC0DE0000 | 32'(i);
    end
    env_mem[8'h10] = 32'hDEADBEEF;
    exp_mem[8'h10] = 32'hDEADBEEF;
    mem_rdata = '0;
    idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mid();
    step();

    // single fetch
    drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    mid();
    chk1("fetch_rdy", if_rdy, 1'b1);
    chk32("fetch_mem_addr", mem_addr, 32'h10);
    step();
    idle();
    mid();
    chk1("fetch_rsp_vld", if_rsp_vld, 1'b1);
    chk32("fetch_rsp_data", if_rsp_data, 32'hDEADBEEF);
    chk1("fetch_no_dm_rsp", dm_rsp_vld, 1'b0);
    step();

    // contention: data wins, fetch follows
    drive(1'b1, 32'h14, 1'b1, 1'b0, 32'h20, 32'h0);
    mid();
    chk1("cont_dm_rdy", dm_rdy, 1'b1);
    chk1("cont_if_rdy", if_rdy, 1'b0);
    chk32("cont_mem_addr", mem_addr, 32'h20);
    step();
    drive(1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0);
    mid();
    chk1("cont_if_late_rdy", if_rdy, 1'b1);
    chk32("cont_dm_rsp_data", dm_rsp_data, 32'hC0DE0020);
    step();
    idle();
    mid();
    step();

    // write then read back-to-back
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 32'h55);
    mid();
    chk1("wr_mem_we", mem_we, 1'b1);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0);
    mid();
    chk1("wr_no_rsp", dm_rsp_vld, 1'b0);
    step();
    idle();
    mid();
    chk1("rd_rsp_vld", dm_rsp_vld, 1'b1);
    chk32("rd_rsp_data", dm_rsp_data, 32'h55);
    step();

    // sustained contention: aging or starvation
    first_if       = -1;
    first_dm_after = -1;
    n_if_gnt       = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h40, 1'b1, 1'b0, 32'h30 + 32'(i), 32'h0);
      mid();
      if (if_rdy) begin
        n_if_gnt++;
        if (first_if < 0) first_if = i;
      end
      if (dm_rdy && first_if >= 0 && first_dm_after < 0) first_dm_after = i;
      step();
    end
`ifdef ARB_AGING_EN
    chk32("aging_first_fetch_cycle", 32'(first_if), 32'd4);
    chk32("aging_data_resumes_cycle", 32'(first_dm_after), 32'd5);
`else
    chk32("starve_fetch_grants", 32'(n_if_gnt), 32'd0);
`endif
    idle();
    mid();
    step();

    // reset during an outstanding read
    drive(1'b1, 32'h50, 1'b0, 1'b0, 32'h0, 32'h0);
    mid();
    chk1("rstmid_grant", if_rdy, 1'b1);
    step();
    rst_n = 1'b0;
    idle();
    mid();
    chk1("rstmid_if_rsp_dropped", if_rsp_vld, 1'b0);
    step();
    mid();
    step();
    rst_n = 1'b1;
    mid();
    chk1("rstmid_post_if_rsp", if_rsp_vld, 1'b0);
    chk1("rstmid_post_dm_rsp", dm_rsp_vld, 1'b0);
    step();
    drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    mid();
    chk1("rstmid_refetch_rdy", if_rdy, 1'b1);
    step();
    idle();
    mid();
    chk32("rstmid_refetch_data", if_rsp_data, 32'hDEADBEEF);
    step();

    // mixed directed vectors, checked by the model
    tv[0] = '{1'b1, 32'h60, 1'b1, 1'b1, 32'h61, 32'h1111};
    tv[1] = '{1'b1, 32'h60, 1'b0, 1'b0, 32'h0,  32'h0};
    tv[2] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h61, 32'h0};
    tv[3] = '{1'b1, 32'h62, 1'b1, 1'b0, 32'h10, 32'h0};
    tv[4] = '{1'b1, 32'h62, 1'b1, 1'b1, 32'h62, 32'h2222};
    tv[5] = '{1'b1, 32'h62, 1'b0, 1'b0, 32'h0,  32'h0};
    tv[6] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0};
    tv[7] = '{1'b1, 32'h61, 1'b0, 1'b0, 32'h0,  32'h0};
    for (int i = 0; i < 8; i++) begin
      drive(tv[i].iv, tv[i].ia, tv[i].dv, tv[i].dwe, tv[i].da, tv[i].dwd);
      mid();
      if (i == 6) chk32("vec_fetch_after_write", if_rsp_data, 32'h2222);
      step();
    end
    idle();
    mid();
    chk32("vec_final_fetch_data", if_rsp_data, 32'h1111);
    step();
    mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
